// File: rtl/lc3b_param_cache.sv
// Direct-mapped write-back, write-allocate cache for the LC-3b CPU.
// Line, index and address widths are parameters; one 16-bit CPU port.
module lc3b_param_cache #(
    parameter int ADDR_BITS   = 16,
    parameter int INDEX_BITS  = 4,
    parameter int OFFSET_BITS = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ADDR_BITS-1:0]             mem_address,
    input  logic                             mem_read,
    input  logic                             mem_write,
    input  logic [1:0]                       mem_byte_enable,
    input  logic [15:0]                      mem_wdata,
    output logic [15:0]                      mem_rdata,
    output logic                             mem_resp,
    output logic [ADDR_BITS-1:0]             pmem_address,
    output logic                             pmem_read,
    output logic                             pmem_write,
    output logic [8*(2**OFFSET_BITS)-1:0]    pmem_wdata,
    input  logic [8*(2**OFFSET_BITS)-1:0]    pmem_rdata,
    input  logic                             pmem_resp
);

    localparam int LINE_BITS = 8 * (2 ** OFFSET_BITS);
    localparam int TAG_BITS  = ADDR_BITS - INDEX_BITS - OFFSET_BITS;
    localparam int SETS      = 2 ** INDEX_BITS;
    localparam int WSEL_BITS = OFFSET_BITS - 1;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH
    } state_t;

    state_t state_q;

    logic [SETS-1:0]      valid_q;
    logic [SETS-1:0]      dirty_q;
    logic [TAG_BITS-1:0]  tag_q  [SETS];
    logic [LINE_BITS-1:0] data_q [SETS];

    // The missing request is latched so a dropped or changed CPU
    // address cannot corrupt an in-flight line transfer.
    logic [TAG_BITS-1:0]   miss_tag_q;
    logic [INDEX_BITS-1:0] miss_idx_q;

    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] req_idx;
    logic [WSEL_BITS-1:0]  req_wsel;
    logic [WSEL_BITS+3:0]  lo_bit;
    logic [WSEL_BITS+3:0]  hi_bit;
    logic                  unused_lsb;

    logic                 req;
    logic                 hit;
    logic                 victim_dirty;
    logic [LINE_BITS-1:0] cur_line;

    assign req_tag    = mem_address[ADDR_BITS-1 -: TAG_BITS];
    assign req_idx    = mem_address[OFFSET_BITS +: INDEX_BITS];
    assign req_wsel   = mem_address[OFFSET_BITS-1:1];
    assign unused_lsb = mem_address[0];

    // Bit positions of the low and high byte of the selected word.
    assign lo_bit = {req_wsel, 4'b0000};
    assign hi_bit = {req_wsel, 4'b1000};

    assign req          = mem_read | mem_write;
    assign cur_line     = data_q[req_idx];
    assign victim_dirty = valid_q[req_idx] & dirty_q[req_idx];

    assign hit = (state_q == IDLE) && req &&
                 valid_q[req_idx] &&
                 (tag_q[req_idx] == req_tag);

    assign mem_rdata = cur_line[lo_bit +: 16];

    // Controller state plus the per-set valid/dirty bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (hit) begin
                        if (mem_write) begin
                            dirty_q[req_idx] <= 1'b1;
                        end
                    end else if (req) begin
                        miss_tag_q <= req_tag;
                        miss_idx_q <= req_idx;
                        if (victim_dirty) begin
                            state_q <= WRITEBACK;
                        end else begin
                            state_q <= FETCH;
                        end
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (pmem_resp) begin
                        valid_q[miss_idx_q] <= 1'b1;
                        dirty_q[miss_idx_q] <= 1'b0;
                        state_q             <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag and data arrays: line fill on fetch return, byte merge on write hit.
    always_ff @(posedge clk) begin
        if ((state_q == FETCH) && pmem_resp) begin
            tag_q[miss_idx_q]  <= miss_tag_q;
            data_q[miss_idx_q] <= pmem_rdata;
        end else if (hit && mem_write) begin
            if (mem_byte_enable[0]) begin
                data_q[req_idx][lo_bit +: 8] <= mem_wdata[7:0];
            end
            if (mem_byte_enable[1]) begin
                data_q[req_idx][hi_bit +: 8] <= mem_wdata[15:8];
            end
        end
    end

    // Physical-side strobes decode straight from state, so reset drops them at once.
    always_comb begin
        mem_resp     = hit;
        pmem_read    = (state_q == FETCH);
        pmem_write   = (state_q == WRITEBACK);
        pmem_wdata   = data_q[miss_idx_q];
        pmem_address = {miss_tag_q, miss_idx_q, {OFFSET_BITS{1'b0}}};
        if (state_q == WRITEBACK) begin
            pmem_address = {tag_q[miss_idx_q], miss_idx_q, {OFFSET_BITS{1'b0}}};
        end
    end

endmodule
